// File: rtl/tt_um_akanksha_hu8785_acc_alu.sv
// Strobed multi-op accumulator ALU (ADD/SUB/NAND/XOR/LOAD/CLR plus 8-step serial MUL) for Tiny Tapeout.
// Define ACC_ALU_SAT_EN to clamp ADD/SUB results instead of wrapping modulo 2^WIDTH.
module tt_um_akanksha_hu8785_acc_alu #(
  parameter int WIDTH    = 16,
  parameter int MUL_BITS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int PW = 16;
  localparam int CW = (MUL_BITS > 1) ? $clog2(MUL_BITS) : 1;

  typedef enum logic {S_IDLE, S_MUL} state_e;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_LOAD = 3'd1,
    OP_ADD  = 3'd2,
    OP_SUB  = 3'd3,
    OP_NAND = 3'd4,
    OP_XOR  = 3'd5,
    OP_MUL  = 3'd6,
    OP_CLR  = 3'd7
  } op_e;

  state_e          state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic            zero_q, zero_d;
  logic            carry_q, carry_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [7:0]      mplier_q, mplier_d;
  logic [PW-1:0]   prod_q, prod_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            s1_q, s2_q, s3_q;
  logic [7:0]      uo_q, uo_d;

  logic            start;
  op_e             op;
  logic [WIDTH-1:0] a_ext;
  logic [WIDTH:0]  sum_w;
  logic [WIDTH:0]  diff_w;
  logic [PW-1:0]   acc_ext;
  logic [PW-1:0]   prod_next;
  logic [WIDTH-1:0] res;
  logic            res_cy;
  logic            upd;
  logic            busy;
  logic            unused_uio;

  assign unused_uio = &{1'b0, uio_in[7:5]};

  assign start   = s2_q & ~s3_q & ena;
  assign op      = op_e'(uio_in[2:0]);
  assign a_ext   = WIDTH'(ui_in);
  assign sum_w   = {1'b0, acc_q} + {1'b0, a_ext};
  assign diff_w  = {1'b0, acc_q} - {1'b0, a_ext};
  // Zero-extend to 16 bits so narrow builds read zero-padded high bytes.
  assign acc_ext = PW'(acc_q);
  assign prod_next = prod_q + (mplier_q[0] ? mcand_q : '0);
  assign busy    = (state_q == S_MUL);

  always_comb begin
    res    = acc_q;
    res_cy = 1'b0;
    upd    = 1'b0;
    unique case (op)
      OP_NOP:  upd = 1'b0;
      OP_LOAD: begin
        res = a_ext;
        upd = 1'b1;
      end
      OP_ADD: begin
        res_cy = sum_w[WIDTH];
        upd    = 1'b1;
`ifdef ACC_ALU_SAT_EN
        res    = sum_w[WIDTH] ? '1 : sum_w[WIDTH-1:0];
`else
        res    = sum_w[WIDTH-1:0];
`endif
      end
      OP_SUB: begin
        res_cy = diff_w[WIDTH];
        upd    = 1'b1;
`ifdef ACC_ALU_SAT_EN
        res    = diff_w[WIDTH] ? '0 : diff_w[WIDTH-1:0];
`else
        res    = diff_w[WIDTH-1:0];
`endif
      end
      OP_NAND: begin
        res = ~(acc_q & a_ext);
        upd = 1'b1;
      end
      OP_XOR: begin
        res = acc_q ^ a_ext;
        upd = 1'b1;
      end
      OP_MUL:  upd = 1'b0;
      OP_CLR: begin
        res = '0;
        upd = 1'b1;
      end
      default: upd = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    uo_d     = uio_in[4] ? acc_ext[15:8] : acc_ext[7:0];

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op == OP_MUL) begin
            state_d  = S_MUL;
            mcand_d  = PW'(acc_q[7:0]);
            mplier_d = ui_in;
            prod_d   = '0;
            cnt_d    = '0;
          end else if (upd) begin
            acc_d   = res;
            zero_d  = (res == '0);
            carry_d = res_cy;
          end
        end
      end
      S_MUL: begin
        // Starts arriving here are dropped, not queued.
        prod_d   = prod_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(MUL_BITS - 1)) begin
          acc_d   = WIDTH'(prod_next);
          zero_d  = (WIDTH'(prod_next) == '0);
          carry_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      zero_q   <= 1'b1;
      carry_q  <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      uo_q     <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      s1_q     <= uio_in[3];
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      uo_q     <= uo_d;
    end
  end

  assign uo_out  = uo_q;
  assign uio_out = {carry_q, zero_q, busy, 5'b0_0000};
  assign uio_oe  = 8'b1110_0000;

endmodule

// File: tb/tb_tt_um_akanksha_hu8785_acc_alu.sv
// Bench for tt_um_akanksha_hu8785_acc_alu: directed vector table, multi-cycle corner sequences, random ops vs model.
module tb_tt_um_akanksha_hu8785_acc_alu;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_MUL  = 3'd6;
  localparam logic [2:0] OP_CLR  = 3'd7;

`ifdef ACC_ALU_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b1;
  logic [7:0] ui_in = '0;
  logic [7:0] uio_in = '0;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  tt_um_akanksha_hu8785_acc_alu #(.WIDTH(16), .MUL_BITS(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  int m_acc = 0;
  bit m_zero = 1'b1;
  bit m_carry = 1'b0;

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a;
    logic [15:0] acc;
    logic        z;
    logic        c;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_op(input logic [2:0] op, input int a);
    int t;
    case (op)
      OP_NOP: return;
      OP_LOAD: begin m_acc = a; m_carry = 0; end
      OP_ADD: begin
        t = m_acc + a;
        m_carry = (t > 65535);
        m_acc = m_carry ? (SAT ? 65535 : t - 65536) : t;
      end
      OP_SUB: begin
        m_carry = (a > m_acc);
        m_acc = m_carry ? (SAT ? 0 : m_acc - a + 65536) : m_acc - a;
      end
      OP_NAND: begin m_acc = (~(m_acc & a)) & 65535; m_carry = 0; end
      OP_XOR:  begin m_acc = m_acc ^ a; m_carry = 0; end
      OP_MUL:  begin m_acc = ((m_acc % 256) * a) % 65536; m_carry = 0; end
      default: begin m_acc = 0; m_carry = 0; end
    endcase
    m_zero = (m_acc == 0);
  endtask

  task automatic set_op(input logic [2:0] op, input logic [7:0] a);
    @(negedge clk);
    ui_in = a;
    uio_in[2:0] = op;
    uio_in[3] = 1'b0;
  endtask

  // Operands settle 3 clocks, strobe held for `hold` clocks, then wait long enough for a MUL to finish.
  task automatic strobe_op(input logic [2:0] op, input logic [7:0] a, input int hold);
    set_op(op, a);
    repeat (3) @(negedge clk);
    uio_in[3] = 1'b1;
    repeat (hold) @(negedge clk);
    uio_in[3] = 1'b0;
    repeat (14) @(negedge clk);
  endtask

  task automatic read_acc(output logic [15:0] v);
    uio_in[4] = 1'b0;
    @(negedge clk);
    v[7:0] = uo_out;
    uio_in[4] = 1'b1;
    @(negedge clk);
    v[15:8] = uo_out;
  endtask

  task automatic check_state(input string tag);
    logic [15:0] v;
    read_acc(v);
    check({tag, " acc"}, 32'(v), 32'(m_acc));
    check({tag, " zero"}, 32'(uio_out[6]), 32'(m_zero));
    check({tag, " carry"}, 32'(uio_out[7]), 32'(m_carry));
    check({tag, " busy"}, 32'(uio_out[5]), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int busy_cnt;
    logic [15:0] v;
    logic [2:0] rop;
    logic [7:0] ra;

    tbl[0]  = '{OP_LOAD, 8'hF0, 16'h00F0, 1'b0, 1'b0};
    tbl[1]  = '{OP_ADD,  8'h20, 16'h0110, 1'b0, 1'b0};
    tbl[2]  = '{OP_LOAD, 8'h05, 16'h0005, 1'b0, 1'b0};
`ifdef ACC_ALU_SAT_EN
    tbl[3]  = '{OP_SUB,  8'h07, 16'h0000, 1'b1, 1'b1};
    tbl[4]  = '{OP_ADD,  8'h05, 16'h0005, 1'b0, 1'b0};
    tbl[5]  = '{OP_NOP,  8'h33, 16'h0005, 1'b0, 1'b0};
`else
    tbl[3]  = '{OP_SUB,  8'h07, 16'hFFFE, 1'b0, 1'b1};
    tbl[4]  = '{OP_ADD,  8'h05, 16'h0003, 1'b0, 1'b1};
    tbl[5]  = '{OP_NOP,  8'h33, 16'h0003, 1'b0, 1'b1};
`endif
    tbl[6]  = '{OP_LOAD, 8'h0C, 16'h000C, 1'b0, 1'b0};
    tbl[7]  = '{OP_MUL,  8'h0D, 16'h009C, 1'b0, 1'b0};
    tbl[8]  = '{OP_LOAD, 8'hAA, 16'h00AA, 1'b0, 1'b0};
    tbl[9]  = '{OP_NAND, 8'h0F, 16'hFFF5, 1'b0, 1'b0};
    tbl[10] = '{OP_XOR,  8'hF5, 16'hFF00, 1'b0, 1'b0};
    tbl[11] = '{OP_CLR,  8'h00, 16'h0000, 1'b1, 1'b0};
    tbl[12] = '{OP_NOP,  8'hFF, 16'h0000, 1'b1, 1'b0};

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset uo_out", 32'(uo_out), 32'h00);
    check("reset uio_out", 32'(uio_out), 32'h40);
    check("reset uio_oe", 32'(uio_oe), 32'hE0);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      strobe_op(tbl[i].op, tbl[i].a, 2);
      read_acc(v);
      check($sformatf("tbl%0d acc", i), 32'(v), 32'(tbl[i].acc));
      check($sformatf("tbl%0d zero", i), 32'(uio_out[6]), 32'(tbl[i].z));
      check($sformatf("tbl%0d carry", i), 32'(uio_out[7]), 32'(tbl[i].c));
      check($sformatf("tbl%0d busy", i), 32'(uio_out[5]), 32'd0);
      m_acc = int'(tbl[i].acc);
      m_zero = tbl[i].z;
      m_carry = tbl[i].c;
    end

    // MUL busy window with a second strobe arriving mid-multiply.
    strobe_op(OP_LOAD, 8'd12, 2);
    model_op(OP_LOAD, 12);
    set_op(OP_MUL, 8'd13);
    repeat (3) @(negedge clk);
    uio_in[3] = 1'b1;
    busy_cnt = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 5) uio_in[3] = 1'b0;
      if (k == 7) uio_in[3] = 1'b1;
      if (k == 9) uio_in[3] = 1'b0;
      if (uio_out[5]) busy_cnt++;
    end
    check("mul busy cycles", 32'(busy_cnt), 32'd8);
    model_op(OP_MUL, 13);
    check_state("mul 12x13");

    // Strobe held high for 20 clocks executes once.
    strobe_op(OP_LOAD, 8'd1, 2);
    model_op(OP_LOAD, 1);
    strobe_op(OP_ADD, 8'd3, 20);
    model_op(OP_ADD, 3);
    check_state("held strobe");

    // ena low blocks new starts.
    ena = 1'b0;
    strobe_op(OP_ADD, 8'd7, 2);
    check_state("ena0 blocked");
    ena = 1'b1;

    // ena dropped mid-MUL lets it complete.
    strobe_op(OP_LOAD, 8'd3, 2);
    model_op(OP_LOAD, 3);
    set_op(OP_MUL, 8'd5);
    repeat (3) @(negedge clk);
    uio_in[3] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 2) uio_in[3] = 1'b0;
      if (k == 5) ena = 1'b0;
    end
    ena = 1'b1;
    model_op(OP_MUL, 5);
    check_state("ena0 mid mul");

    // Asynchronous reset in the middle of a multiply.
    strobe_op(OP_LOAD, 8'd12, 2);
    model_op(OP_LOAD, 12);
    uio_in[4] = 1'b0;
    repeat (2) @(negedge clk);
    check("pre-reset uo_out", 32'(uo_out), 32'h0C);
    set_op(OP_MUL, 8'd13);
    repeat (3) @(negedge clk);
    uio_in[3] = 1'b1;
    repeat (5) @(negedge clk);
    uio_in[3] = 1'b0;
    check("pre-reset busy", 32'(uio_out), 32'h20);
    #2 rst_n = 1'b0;
    #1;
    check("async reset uo_out", 32'(uo_out), 32'h00);
    check("async reset uio_out", 32'(uio_out), 32'h40);
    check("async reset uio_oe", 32'(uio_oe), 32'hE0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_acc = 0;
    m_zero = 1'b1;
    m_carry = 1'b0;
    repeat (12) @(negedge clk);
    check_state("after mid-mul reset");

    for (int n = 0; n < 40; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra = 8'($urandom_range(0, 255));
      strobe_op(rop, ra, 1 + int'($urandom_range(0, 3)));
      model_op(rop, int'(ra));
      check_state($sformatf("rand%0d op%0d a%0h", n, rop, ra));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
